// File: rtl/sdram_pkg.sv
// Shared definitions for the SDRAM command scheduler: call encodings, FSM states,
// address field widths and timing defaults.
package sdram_pkg;

    localparam int BA_W   = 2;
    localparam int ROW_W  = 13;
    localparam int COL_W  = 9;
    localparam int ADDR_W = BA_W + ROW_W + COL_W;
    localparam int DATA_W = 16;
    localparam int CALL_W = 4;

    localparam logic [CALL_W-1:0] CALL_NONE = 4'b0000;
    localparam logic [CALL_W-1:0] CALL_WR   = 4'b1000;
    localparam logic [CALL_W-1:0] CALL_RD   = 4'b0100;
    localparam logic [CALL_W-1:0] CALL_REF  = 4'b0010;
    localparam logic [CALL_W-1:0] CALL_INIT = 4'b0001;

    localparam int REF_INTERVAL_DEF = 1040;
    localparam int DONE_TIMEOUT_DEF = 16384;
    localparam int TCNT_W_DEF       = 15;

    typedef enum logic [2:0] {
        S_INIT,
        S_IDLE,
        S_REF,
        S_WR,
        S_RD
    } state_e;

    typedef enum logic {
        SERVED_WR,
        SERVED_RD
    } served_e;

endpackage

// File: rtl/sdram_cmd_scheduler_if.sv
// Requester and engine bus of the scheduler. The slave modport is the scheduler's
// view; the master modport is the combined requester/engine side.
interface sdram_cmd_scheduler_if;
    import sdram_pkg::*;

    logic              wr_req;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              wr_ack;
    logic              rd_req;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic [CALL_W-1:0] sd_call;
    logic              sd_done;
    logic [ADDR_W-1:0] sd_addr;
    logic [DATA_W-1:0] sd_wdata;
    logic [DATA_W-1:0] sd_rdata;

    modport slave (
        input  wr_req, wr_addr, wr_data, rd_req, rd_addr, sd_done, sd_rdata,
        output wr_ack, rd_data, rd_valid, sd_call, sd_addr, sd_wdata
    );

    modport master (
        output wr_req, wr_addr, wr_data, rd_req, rd_addr, sd_done, sd_rdata,
        input  wr_ack, rd_data, rd_valid, sd_call, sd_addr, sd_wdata
    );

endinterface

// File: rtl/sdram_ref_timer.sv
// Refresh interval timer: raises ref_pending every REF_INTERVAL clocks once enabled
// and flags a late refresh when an interval expires with one still outstanding.
module sdram_ref_timer
    import sdram_pkg::*;
#(
    parameter int REF_INTERVAL = REF_INTERVAL_DEF,
    parameter int TCNT_W       = TCNT_W_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic en_i,
    input  logic clear_i,
    input  logic take_i,
    output logic ref_pending_o,
    output logic err_ref_late_o
);

    logic [TCNT_W-1:0] cnt_q;
    logic              pending_q;
    logic              late_q;
    logic              wrap;

    assign wrap = en_i && !clear_i && (cnt_q == TCNT_W'(REF_INTERVAL - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q     <= '0;
            pending_q <= 1'b0;
            late_q    <= 1'b0;
        end else begin
            if (clear_i || wrap) begin
                cnt_q <= '0;
            end else if (en_i) begin
                cnt_q <= cnt_q + TCNT_W'(1);
            end
            // A wrap on the cycle the old request is granted starts a fresh request.
            if (wrap) begin
                pending_q <= 1'b1;
                if (pending_q && !take_i) begin
                    late_q <= 1'b1;
                end
            end else if (take_i) begin
                pending_q <= 1'b0;
            end
        end
    end

    assign ref_pending_o  = pending_q;
    assign err_ref_late_o = late_q;

endmodule

// File: rtl/sdram_cmd_scheduler.sv
// Sole driver of the SDRAM engine call vector: init, periodic refresh and
// alternating write/read service, each call guarded by a done watchdog.
module sdram_cmd_scheduler
    import sdram_pkg::*;
#(
    parameter int REF_INTERVAL = REF_INTERVAL_DEF,
    parameter int DONE_TIMEOUT = DONE_TIMEOUT_DEF,
    parameter int TCNT_W       = TCNT_W_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    sdram_cmd_scheduler_if.slave  bus,
    output logic                  init_done,
    output logic                  busy,
    output logic                  err_timeout,
    output logic                  err_ref_late
);

    state_e            state_q;
    served_e           last_q;
    logic [CALL_W-1:0] call_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata_q;
    logic              wr_ack_q;
    logic              rd_valid_q;
    logic              init_done_q;
    logic              err_timeout_q;
    logic [TCNT_W-1:0] wdog_q;

    logic ref_pending;
    logic ref_take;
    logic ref_clear;
    logic wdog_hit;

    assign ref_take  = (state_q == S_IDLE) && ref_pending;
    assign ref_clear = (state_q == S_INIT) && (call_q != CALL_NONE) && bus.sd_done;
    assign wdog_hit  = (wdog_q == TCNT_W'(DONE_TIMEOUT - 1));

    sdram_ref_timer #(
        .REF_INTERVAL (REF_INTERVAL),
        .TCNT_W       (TCNT_W)
    ) u_ref_timer (
        .clk            (clk),
        .rst            (rst),
        .en_i           (init_done_q),
        .clear_i        (ref_clear),
        .take_i         (ref_take),
        .ref_pending_o  (ref_pending),
        .err_ref_late_o (err_ref_late)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_INIT;
            last_q        <= SERVED_RD;
            call_q        <= CALL_NONE;
            addr_q        <= '0;
            wdata_q       <= '0;
            rdata_q       <= '0;
            wr_ack_q      <= 1'b0;
            rd_valid_q    <= 1'b0;
            init_done_q   <= 1'b0;
            err_timeout_q <= 1'b0;
            wdog_q        <= '0;
        end else begin
            wr_ack_q   <= 1'b0;
            rd_valid_q <= 1'b0;
            case (state_q)
                S_INIT: begin
                    // call_q == 0 here means a fresh start or a retry after a timeout.
                    if (call_q == CALL_NONE) begin
                        call_q <= CALL_INIT;
                        wdog_q <= '0;
                    end else if (bus.sd_done) begin
                        call_q      <= CALL_NONE;
                        init_done_q <= 1'b1;
                        state_q     <= S_IDLE;
                    end else if (wdog_hit) begin
                        call_q        <= CALL_NONE;
                        err_timeout_q <= 1'b1;
                    end else begin
                        wdog_q <= wdog_q + TCNT_W'(1);
                    end
                end
                S_IDLE: begin
                    wdog_q <= '0;
                    if (ref_pending) begin
                        call_q  <= CALL_REF;
                        state_q <= S_REF;
                    end else if (bus.wr_req && (!bus.rd_req || last_q == SERVED_RD)) begin
                        call_q  <= CALL_WR;
                        addr_q  <= bus.wr_addr;
                        wdata_q <= bus.wr_data;
                        state_q <= S_WR;
                    end else if (bus.rd_req) begin
                        call_q  <= CALL_RD;
                        addr_q  <= bus.rd_addr;
                        state_q <= S_RD;
                    end
                end
                S_REF, S_WR, S_RD: begin
                    // The call must fall on the done edge or the engine restarts.
                    if (bus.sd_done) begin
                        call_q  <= CALL_NONE;
                        state_q <= S_IDLE;
                        if (state_q == S_WR) begin
                            wr_ack_q <= 1'b1;
                            last_q   <= SERVED_WR;
                        end
                        if (state_q == S_RD) begin
                            rd_valid_q <= 1'b1;
                            rdata_q    <= bus.sd_rdata;
                            last_q     <= SERVED_RD;
                        end
                    end else if (wdog_hit) begin
                        call_q        <= CALL_NONE;
                        err_timeout_q <= 1'b1;
                        state_q       <= S_IDLE;
                    end else begin
                        wdog_q <= wdog_q + TCNT_W'(1);
                    end
                end
                default: begin
                    call_q  <= CALL_NONE;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.sd_call  = call_q;
    assign bus.sd_addr  = addr_q;
    assign bus.sd_wdata = wdata_q;
    assign bus.rd_data  = rdata_q;
    assign bus.wr_ack   = wr_ack_q;
    assign bus.rd_valid = rd_valid_q;
    assign init_done    = init_done_q;
    assign busy         = (call_q != CALL_NONE);
    assign err_timeout  = err_timeout_q;

endmodule

// File: tb/tb_sdram_cmd_scheduler.sv
// Directed bench for sdram_cmd_scheduler with a behavioural engine that answers each
// call with a done pulse after a per-call delay.
module tb_sdram_cmd_scheduler;
    import sdram_pkg::*;

    localparam int INIT_DLY = 13310;
    localparam int REF_DLY  = 30;
    localparam int RW_DLY   = 12;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic init_done, busy, err_timeout, err_ref_late;

    sdram_cmd_scheduler_if bus();

    sdram_cmd_scheduler dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus),
        .init_done    (init_done),
        .busy         (busy),
        .err_timeout  (err_timeout),
        .err_ref_late (err_ref_late)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Engine model: done rises dly cycles after the call appears (call held dly+1 clocks).
    logic withhold_rd = 1'b0;
    int   eng_cnt = 0;

    function automatic int eng_delay(input logic [3:0] c);
        if (c == CALL_INIT) return INIT_DLY;
        if (c == CALL_REF)  return REF_DLY;
        return RW_DLY;
    endfunction

    always @(posedge clk) begin
        if (rst || bus.sd_call == CALL_NONE) begin
            eng_cnt     <= 0;
            bus.sd_done <= 1'b0;
        end else if (bus.sd_done) begin
            bus.sd_done <= 1'b0;
        end else begin
            eng_cnt <= eng_cnt + 1;
            if (!(withhold_rd && bus.sd_call == CALL_RD) && eng_cnt == eng_delay(bus.sd_call) - 1)
                bus.sd_done <= 1'b1;
        end
    end

    // Monitor: logs call launches, hold lengths, acks and protocol violations.
    int          cyc = 0;
    logic [3:0]  call_log[$];
    logic [23:0] addr_log[$];
    logic [15:0] wdata_log[$];
    int          pend_rise[$];
    logic [3:0]  prev_call = '0;
    logic [23:0] prev_addr = '0;
    logic [15:0] prev_wdata = '0;
    logic        prev_done_hi = 1'b0;
    logic        prev_pend = 1'b0;
    int          call_len = 0;
    int          last_len = 0;
    int          wr_ack_cnt = 0;
    int          rd_valid_cnt = 0;
    int          proto_err = 0;

    always @(posedge clk) begin
        #1;
        cyc++;
        if (rst) begin
            prev_call    = '0;
            prev_done_hi = 1'b0;
            prev_pend    = 1'b0;
            call_len     = 0;
        end else begin
            if (bus.sd_call != CALL_NONE) begin
                if ($countones(bus.sd_call) != 1) proto_err++;
                if (prev_call == CALL_NONE) begin
                    call_log.push_back(bus.sd_call);
                    addr_log.push_back(bus.sd_addr);
                    wdata_log.push_back(bus.sd_wdata);
                    call_len = 1;
                end else begin
                    call_len++;
                    if (bus.sd_call != prev_call || bus.sd_addr != prev_addr ||
                        bus.sd_wdata != prev_wdata) proto_err++;
                end
            end else if (prev_call != CALL_NONE) begin
                last_len = call_len;
            end
            if (prev_done_hi && bus.sd_call != CALL_NONE) proto_err++;
            if (busy != (bus.sd_call != CALL_NONE)) proto_err++;
            if (bus.wr_ack) wr_ack_cnt++;
            if (bus.rd_valid) rd_valid_cnt++;
            if (dut.u_ref_timer.ref_pending_o && !prev_pend) pend_rise.push_back(cyc);
            prev_pend    = dut.u_ref_timer.ref_pending_o;
            prev_done_hi = bus.sd_done && (bus.sd_call != CALL_NONE);
            prev_call    = bus.sd_call;
            prev_addr    = bus.sd_addr;
            prev_wdata   = bus.sd_wdata;
        end
    end

    initial begin
        int n, s, w0, r0, nw, nr, nref, alt_err;
        logic [3:0] last_t, first_t;
        logic wr_on, rd_on;

        bus.wr_req = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
        bus.rd_req = 1'b0; bus.rd_addr = '0; bus.sd_rdata = '0;

        // 1: reset state and init call
        repeat (3) @(negedge clk);
        check("rst_sd_call", bus.sd_call, CALL_NONE);
        check("rst_sd_addr", bus.sd_addr, 0);
        check("rst_rd_data", bus.rd_data, 0);
        check("rst_flags", {init_done, busy, err_timeout, err_ref_late, bus.wr_ack, bus.rd_valid}, 0);
        rst = 1'b0;
        @(negedge clk);
        check("init_call_first_cycle", bus.sd_call, CALL_INIT);
        check("init_busy", busy, 1);
        n = 0;
        do begin @(negedge clk); n++; end while (!init_done && n < 20000);
        check("init_done_seen", init_done, 1);
        check("init_call_dropped", bus.sd_call, CALL_NONE);
        check("init_hold_len", last_len, INIT_DLY + 1);
        check("init_call_count", call_log.size(), 1);
        check("init_no_acks", wr_ack_cnt + rd_valid_cnt, 0);

        // 2: single write
        bus.wr_addr = 24'h8A1234; bus.wr_data = 16'hBEEF; bus.wr_req = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!bus.wr_ack && n < 200);
        check("wr_ack_seen", bus.wr_ack, 1);
        bus.wr_req = 1'b0;
        check("wr_call_dropped", bus.sd_call, CALL_NONE);
        check("wr_call", call_log[call_log.size()-1], CALL_WR);
        check("wr_addr", addr_log[addr_log.size()-1], 24'h8A1234);
        check("wr_wdata", wdata_log[wdata_log.size()-1], 16'hBEEF);
        check("wr_hold_len", last_len, RW_DLY + 1);
        repeat (3) @(negedge clk);
        check("wr_ack_once", wr_ack_cnt, 1);

        // 3: single read
        bus.rd_addr = 24'h000010; bus.sd_rdata = 16'h5A5A; bus.rd_req = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!bus.rd_valid && n < 200);
        check("rd_valid_seen", bus.rd_valid, 1);
        bus.rd_req = 1'b0;
        check("rd_data", bus.rd_data, 16'h5A5A);
        check("rd_call", call_log[call_log.size()-1], CALL_RD);
        check("rd_addr", addr_log[addr_log.size()-1], 24'h000010);
        repeat (3) @(negedge clk);
        check("rd_valid_once", rd_valid_cnt, 1);

        // 4: both requesters held, refresh insertion
        s = call_log.size(); w0 = wr_ack_cnt; r0 = rd_valid_cnt;
        bus.wr_addr = 24'h111111; bus.wr_data = 16'h1111; bus.rd_addr = 24'h222222;
        bus.sd_rdata = 16'h2222;
        bus.wr_req = 1'b1; bus.rd_req = 1'b1;
        repeat (3200) @(negedge clk);
        wr_on = 1'b1; rd_on = 1'b1; n = 0;
        while ((wr_on || rd_on) && n < 400) begin
            @(negedge clk); n++;
            if (bus.wr_ack) begin bus.wr_req = 1'b0; wr_on = 1'b0; end
            if (bus.rd_valid) begin bus.rd_req = 1'b0; rd_on = 1'b0; end
        end
        check("alt_drain_done", {wr_on, rd_on}, 0);
        repeat (40) @(negedge clk);
        nw = 0; nr = 0; nref = 0; alt_err = 0; last_t = CALL_NONE; first_t = CALL_NONE;
        for (int i = s; i < call_log.size(); i++) begin
            if (call_log[i] == CALL_REF) nref++;
            else begin
                if (first_t == CALL_NONE) first_t = call_log[i];
                if (call_log[i] == last_t) alt_err++;
                last_t = call_log[i];
                if (call_log[i] == CALL_WR) nw++; else nr++;
            end
        end
        check("alt_first_is_write", first_t, CALL_WR);
        check("alt_errors", alt_err, 0);
        check("alt_refresh_inserted", nref >= 3, 1);
        check("alt_wr_acks", wr_ack_cnt - w0, nw);
        check("alt_rd_valids", rd_valid_cnt - r0, nr);
        check("alt_ref_rises", pend_rise.size() >= 3, 1);
        for (int i = 1; i < pend_rise.size(); i++)
            check($sformatf("ref_interval_%0d", i), pend_rise[i] - pend_rise[i-1], REF_INTERVAL_DEF);
        check("alt_no_ref_late", err_ref_late, 0);

        // 5: read watchdog timeout and retry
        r0 = rd_valid_cnt;
        withhold_rd = 1'b1;
        bus.rd_addr = 24'h0ABCDE; bus.sd_rdata = 16'hC3C3; bus.rd_req = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!err_timeout && n < 18000);
        check("to_err_timeout", err_timeout, 1);
        withhold_rd = 1'b0;
        check("to_call_dropped", bus.sd_call, CALL_NONE);
        check("to_timed_out_call", call_log[call_log.size()-1], CALL_RD);
        check("to_hold_len", last_len, DONE_TIMEOUT_DEF);
        check("to_no_valid", rd_valid_cnt, r0);
        check("to_ref_late", err_ref_late, 1);
        s = call_log.size();
        n = 0;
        do begin @(negedge clk); n++; end while (!bus.rd_valid && n < 300);
        check("to_retry_valid", bus.rd_valid, 1);
        bus.rd_req = 1'b0;
        check("to_retry_data", bus.rd_data, 16'hC3C3);
        check("to_ref_first", call_log[s], CALL_REF);
        check("to_retry_call", call_log[s+1], CALL_RD);
        check("to_retry_addr", addr_log[s+1], 24'h0ABCDE);
        repeat (3) @(negedge clk);
        check("to_valid_once", rd_valid_cnt, r0 + 1);
        check("to_timeout_sticky", err_timeout, 1);

        // 6: reset in the middle of a write
        bus.wr_addr = 24'h123456; bus.wr_data = 16'h7777; bus.wr_req = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (bus.sd_call != CALL_WR && n < 200);
        check("mid_wr_call", bus.sd_call, CALL_WR);
        repeat (3) @(negedge clk);
        w0 = wr_ack_cnt;
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_call", bus.sd_call, CALL_NONE);
        check("mid_rst_flags", {init_done, busy, err_timeout, err_ref_late, bus.wr_ack}, 0);
        check("mid_rst_addr", bus.sd_addr, 0);
        bus.wr_req = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        s = call_log.size();
        n = 0;
        do begin @(negedge clk); n++; end while (!init_done && n < 20000);
        check("reinit_done", init_done, 1);
        check("reinit_call", call_log[s], CALL_INIT);
        check("reinit_one_call", call_log.size(), s + 1);
        check("reinit_hold_len", last_len, INIT_DLY + 1);
        repeat (5) @(negedge clk);
        check("reinit_no_stale_ack", wr_ack_cnt, w0);
        check("protocol_errors", proto_err, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sdram_cmd_scheduler.md
Name: sdram_cmd_scheduler

Overview:
- Upstream controller for the SDRAM function engine; it is the only driver of that engine's 4-bit one-hot call vector.
- After reset it issues the power-on initial call, then periodically issues refresh calls.
- Between refreshes it arbitrates single-word write and read requests from the photon-counter datapath.
- It holds each call until the engine's one-cycle done pulse arrives, returns read data and acks to the requesters, and guards every call with a watchdog.

Parameters:
REF_INTERVAL, 1040, clocks between refresh requests (7.8 us at 133 MHz).
DONE_TIMEOUT, 16384, maximum clocks a call may stay asserted without done; must exceed the 13300-clock init delay.
TCNT_W, 15, width of the refresh and watchdog counters.

Ports:
clk  in  1  system clock, 133 MHz.
rst  in  1  synchronous reset, active-high.
wr_req  in  1  write request; level, held until wr_ack.
wr_addr  in  24  write address, {bank[1:0], row[12:0], col[8:0]}; stable while wr_req.
wr_data  in  16  write data; stable while wr_req.
wr_ack  out  1  one-cycle pulse when the write completes.
rd_req  in  1  read request; level, held until rd_valid.
rd_addr  in  24  read address; stable while rd_req.
rd_data  out  16  read data, registered.
rd_valid  out  1  one-cycle pulse; rd_data is valid in the same cycle.
sd_call  out  4  one-hot call: [3] write, [2] read, [1] refresh, [0] init.
sd_done  in  1  done pulse from the engine.
sd_addr  out  24  address to the engine.
sd_wdata  out  16  write data to the engine.
sd_rdata  in  16  read data from the engine.
init_done  out  1  high once the init call has completed; sticky until rst.
busy  out  1  high whenever sd_call != 0.
err_timeout  out  1  sticky watchdog error.
err_ref_late  out  1  sticky: refresh interval expired while a refresh was already pending.

Behaviour:
- Reset (synchronous, rst=1):
  - Outputs: sd_call=0, sd_addr=0, sd_wdata=0, rd_data=0, and wr_ack, rd_valid, init_done, busy, err_timeout, err_ref_late all 0.
  - Internal: counters=0, ref_pending=0, last_served=READ, state=S_INIT.
  - Asserting rst mid-call drops sd_call to 0 on the next edge. No completion is reported for the aborted request.
- States: S_INIT, S_IDLE, S_REF, S_WR, S_RD.
- S_INIT:
  - sd_call=4'b0001 is asserted on the first cycle after reset release.
  - On sd_done: sd_call<=0, init_done<=1, refresh counter cleared, go to S_IDLE.
- S_IDLE: selects at most one call per cycle; the call is registered, so sd_call rises 1 clock after the decision. Priority:
  1. ref_pending: sd_call=4'b0010, go to S_REF, ref_pending<=0.
  2. Both wr_req and rd_req: serve the type opposite to last_served.
  3. Only wr_req: sd_call=4'b1000; sd_addr<=wr_addr, sd_wdata<=wr_data; go to S_WR.
  4. Only rd_req: sd_call=4'b0100; sd_addr<=rd_addr; go to S_RD.
- Call states (S_REF, S_WR, S_RD):
  - sd_call, sd_addr and sd_wdata are held constant.
  - On the edge sampling sd_done=1: sd_call<=0, return to S_IDLE, update last_served.
  - S_WR additionally pulses wr_ack.
  - S_RD additionally pulses rd_valid with rd_data<=sd_rdata.
  - Clearing sd_call on the done edge is mandatory: the engine restarts its sequence if the call is still high one cycle after done.
- Minimum gap: one S_IDLE cycle with sd_call=0 between consecutive calls.
- Refresh timer:
  - Runs only when init_done=1; counts 0..REF_INTERVAL-1, wraps, and sets ref_pending on wrap.
  - If the wrap occurs while ref_pending=1: err_ref_late<=1, and ref_pending stays 1.
  - A refresh request arriving during S_WR or S_RD waits for that call to finish. It then wins S_IDLE even if requests are pending.
- Watchdog:
  - Counter clears on every call launch and counts while sd_call != 0.
  - Reaching DONE_TIMEOUT-1 without sd_done: sd_call<=0, err_timeout<=1, no ack or valid is issued.
  - Next state: S_INIT if the timed-out call was init (init retried); otherwise S_IDLE, where the still-held request is retried.
- sd_done while sd_call=0: ignored.
- Requests are never dropped. A requester that deasserts req before its ack is a protocol violation and need not be handled.
- Throughput bound: a refresh blocks user traffic for roughly 30 clocks; a write or read takes about 11–13 clocks plus 2 clocks of handshake overhead.

Decomposition:
- Shared package sdram_pkg:
  - one-hot call encodings CALL_WR=4'b1000, CALL_RD=4'b0100, CALL_REF=4'b0010, CALL_INIT=4'b0001;
  - state encoding;
  - address field widths (BA=2, ROW=13, COL=9);
  - REF_INTERVAL and DONE_TIMEOUT defaults.
- One natural sub-module: sdram_ref_timer, containing the refresh counter, ref_pending, and err_ref_late.

Test Plan:
1. Reset release with a behavioural engine model that pulses done 13310 clocks after init → sd_call=0001 held until done, then 0; init_done=1; no wr_ack or rd_valid.
2. wr_req with addr 24'h8A_1234, data 16'hBEEF → sd_call=1000 with sd_addr=8A1234 and sd_wdata=BEEF held; wr_ack pulses once on the done edge; sd_call=0 the next cycle.
3. rd_req at 24'h00_0010 with the model returning 16'h5A5A → exactly one rd_valid pulse with rd_data=5A5A.
4. wr_req and rd_req both held continuously → served alternately W,R,W,R. After 1040 clocks a refresh (0010) is inserted ahead of the pending request. Interval from each refresh timer wrap to the next: 1040 clocks ±0.
5. Model withholds done for a read → sd_call drops at DONE_TIMEOUT-1, err_timeout=1, the read is reissued, and the next done yields rd_valid.
6. rst=1 asserted mid-write → next edge sd_call=0 and all flags cleared; after release the init call is reissued and no stale wr_ack appears.
